// File: rtl/camera_readout_if.sv
// Signal bundle between the camera controller side, camera_readout and the
// downstream pixel consumer.
interface camera_readout_if #(
    parameter int DATA_W = 8
);
    logic              erase;
    logic              expose;
    logic              nre1;
    logic              nre2;
    logic              adc;
    logic [DATA_W-1:0] adc_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;
    logic              frame_done;
    logic              overrun;
    logic              proto_err;

    // Master drives the sensor strobes and consumes the pixel stream.
    modport master (
        output erase, expose, nre1, nre2, adc, adc_data, pix_ready,
        input  pix_data, pix_valid, pix_last, frame_done, overrun, proto_err
    );

    modport slave (
        input  erase, expose, nre1, nre2, adc, adc_data, pix_ready,
        output pix_data, pix_valid, pix_last, frame_done, overrun, proto_err
    );
endinterface

// File: rtl/camera_readout.sv
// Captures a 2 x SIZE frame from the camera_control strobes and streams it out.
// Optional BLACK_CLAMP_EN: subtract BLACK_LVL (saturating) at capture time.
module camera_readout #(
    parameter int SIZE   = 2,
    parameter int DATA_W = 8
`ifdef BLACK_CLAMP_EN
    ,
    parameter logic [DATA_W-1:0] BLACK_LVL = 8'd16
`endif
) (
    input logic       clk,
    input logic       reset,
    camera_readout_if.slave bus
);

    localparam int COL_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SIZE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ERASED = 3'd1;
    localparam logic [2:0] S_EXPOSE = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]        r_state;
    logic              r_adc_q;
    logic              r_adc_rise;
    logic              r_nre1_q;
    logic              r_nre2_q;
    logic [DATA_W-1:0] r_adc_data_q;
    logic [DATA_W-1:0] r_buf [2][SIZE];
    logic [COL_W-1:0]  r_col;
    logic              r_row;
    logic [COL_W-1:0]  r_rd_col;
    logic              r_rd_row;
    logic              r_pix_valid;
    logic              r_frame_done;
    logic              r_overrun;
    logic              r_proto_err;
    logic              r_erase_pend;

    logic [DATA_W-1:0] w_sample;
    logic              w_row_ok;
    logic              w_row_sel;
    logic              w_capture;
    logic              w_xfer;
    logic              w_rd_last;

    // Exactly one of the two row enables must be low for a sample to count.
    assign w_row_ok  = r_nre1_q ^ r_nre2_q;
    assign w_row_sel = r_nre1_q;
    assign w_capture = (r_state == S_READ) && r_adc_rise && w_row_ok && !bus.erase;
    assign w_xfer    = r_pix_valid && bus.pix_ready;
    assign w_rd_last = r_rd_row && (r_rd_col == COL_LAST);

`ifdef BLACK_CLAMP_EN
    assign w_sample = (r_adc_data_q > BLACK_LVL) ? (r_adc_data_q - BLACK_LVL) : '0;
`else
    assign w_sample = r_adc_data_q;
`endif

    // Input stage: adc edge detect plus the row enables and data that go with it.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adc_q      <= 1'b0;
            r_adc_rise   <= 1'b0;
            r_nre1_q     <= 1'b1;
            r_nre2_q     <= 1'b1;
            r_adc_data_q <= '0;
        end else begin
            r_adc_q      <= bus.adc;
            r_adc_rise   <= bus.adc & ~r_adc_q;
            r_nre1_q     <= bus.nre1;
            r_nre2_q     <= bus.nre2;
            r_adc_data_q <= bus.adc_data;
        end
    end

    // NOTE: the frame buffer is only 2*SIZE words, so it is reset along with
    // everything else; a large RAM would be left unreset instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else if (w_capture) begin
            r_buf[w_row_sel][r_col] <= w_sample;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= 1'b0;
            r_rd_col     <= '0;
            r_rd_row     <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_proto_err  <= 1'b0;
            r_erase_pend <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.erase) r_state <= S_ERASED;
                end
                S_ERASED: begin
                    if (bus.expose) r_state <= S_EXPOSE;
                end
                S_EXPOSE: begin
                    if (bus.erase) begin
                        r_state <= S_ERASED;
                    end else if (!bus.expose) begin
                        r_state <= S_READ;
                        r_col   <= '0;
                        r_row   <= 1'b0;
                    end
                end
                S_READ: begin
                    if (bus.erase) begin
                        r_state <= S_ERASED;
                        r_col   <= '0;
                        r_row   <= 1'b0;
                    end else if (r_adc_rise && !w_row_ok) begin
                        r_proto_err <= 1'b1;
                    end else if (w_capture) begin
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            if (r_row) begin
                                // Last sample lands this edge; drain starts with it.
                                r_row        <= 1'b0;
                                r_frame_done <= 1'b1;
                                r_state      <= S_DRAIN;
                                r_rd_col     <= '0;
                                r_rd_row     <= 1'b0;
                                r_pix_valid  <= 1'b1;
                                r_erase_pend <= 1'b0;
                            end else begin
                                r_row <= 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.erase) begin
                        r_overrun    <= 1'b1;
                        r_erase_pend <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_rd_last) begin
                            r_pix_valid <= 1'b0;
                            r_state     <= (r_erase_pend || bus.erase) ? S_ERASED : S_IDLE;
                        end else if (r_rd_col == COL_LAST) begin
                            r_rd_col <= '0;
                            r_rd_row <= 1'b1;
                        end else begin
                            r_rd_col <= r_rd_col + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        bus.pix_data = '0;
        if (r_pix_valid) bus.pix_data = r_buf[r_rd_row][r_rd_col];
    end

    assign bus.pix_valid  = r_pix_valid;
    assign bus.pix_last   = r_pix_valid && w_rd_last;
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;
    assign bus.proto_err  = r_proto_err;

endmodule
